// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and
// commits results to the architectural HI/LO pair with a single done pulse.
module hilo_muldiv_ctrl #(
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on a rising edge with start=1, busy=0 and
  // op<=5; anything presented while busy=1 is dropped, never queued.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [5:0] MUL_LAST = 6'(MULT_LAT);
  localparam logic [5:0] DIV_LAST = 6'd33;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] opa;        // MUL: multiplicand; DIV: raw dividend (divide-by-zero HI)
  logic [31:0] opb;        // MUL: multiplier; DIV: divisor magnitude
  logic        mul_signed;
  logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;

  logic        accept;
  logic        div_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] product;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept     = start && (state == S_IDLE) && (op <= OP_MTLO);
  assign div_signed = (op == OP_DIV);
  assign rs_mag     = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
  assign rt_mag     = (div_signed && rt[31]) ? (32'd0 - rt) : rt;

  assign prod_s  = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
  assign prod_u  = {32'd0, opa} * {32'd0, opb};
  assign product = mul_signed ? prod_s : prod_u;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not go negative.
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, opb};

  assign q_fix = q_neg ? (32'd0 - quo) : quo;
  assign r_fix = r_neg ? (32'd0 - rem) : rem;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      opa        <= 32'd0;
      opb        <= 32'd0;
      mul_signed <= 1'b0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opa        <= rs;
                opb        <= rt;
                mul_signed <= (op == OP_MULT);
                cnt        <= 6'd1;
                busy       <= 1'b1;
                state      <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                opa      <= rs;
                opb      <= rt_mag;
                quo      <= rs_mag;
                rem      <= 32'd0;
                q_neg    <= div_signed && (rs[31] ^ rt[31]);
                r_neg    <= div_signed && rs[31];
                div_zero <= (rt == 32'd0);
                cnt      <= 6'd1;
                busy     <= 1'b1;
                state    <= S_DIV;
              end
              OP_MTHI: hi <= rs;
              OP_MTLO: lo <= rs;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == MUL_LAST) begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= 6'd0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        S_DIV: begin
          if (cnt == DIV_LAST) begin
            // Divide-by-zero leaves the dividend in HI and skips sign fix-up.
            if (div_zero) begin
              hi <= opa;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= 6'd0;
            state <= S_IDLE;
          end else begin
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= 6'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed plus randomized bench for hilo_muldiv_ctrl against an arithmetic
// reference model of HI/LO.
module tb_hilo_muldiv_ctrl;

  localparam int MULT_LAT = 2;
  localparam int DIV_LAT  = 33;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  hilo_muldiv_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {hi, lo} after the operation completes.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ohi,
                                        input logic [31:0] olo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, olo};
      3'd5: return {ohi, a};
      default: return {ohi, olo};
    endcase
  endfunction

  // Issues one request, follows it to completion and checks every busy cycle.
  // noise=1 fires refused requests (MTHI 0xDEAD, MULT, random) while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic [63:0] e;
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; rs = $urandom; rt = $urandom;
    e = model(o, a, b, m_hi, m_lo);
    if (o > 3'd5) begin
      chk("rsv_busy", {31'd0, busy}, 32'd0);
      chk("rsv_done", {31'd0, done}, 32'd0);
      chk("rsv_hi", hi, m_hi);
      chk("rsv_lo", lo, m_lo);
      return;
    end
    if (o >= 3'd4) begin
      m_hi = e[63:32]; m_lo = e[31:0];
      chk("mt_busy", {31'd0, busy}, 32'd0);
      chk("mt_done", {31'd0, done}, 32'd0);
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      return;
    end
    lat = (o < 3'd2) ? MULT_LAT : DIV_LAT;
    for (int k = 0; k < lat; k++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_done", {31'd0, done}, 32'd0);
      chk("run_hi_hold", hi, m_hi);
      chk("run_lo_hold", lo, m_lo);
      if (noise) begin
        @(negedge clk);
        start = 1'b1;
        case (k % 3)
          0: begin op = 3'd4; rs = 32'h0000_DEAD; end
          1: begin op = 3'd0; rs = $urandom; end
          default: begin op = 3'($urandom_range(0, 7)); rs = $urandom; end
        endcase
        rt = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    m_hi = e[63:32]; m_lo = e[31:0];
    chk("cmt_busy", {31'd0, busy}, 32'd0);
    chk("cmt_done", {31'd0, done}, 32'd1);
    chk("cmt_hi", hi, m_hi);
    chk("cmt_lo", lo, m_lo);
  endtask

  initial begin
    int done_seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    // MULT/MULTU sign handling; first one accepted on the first edge after reset
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mult_hi_lit", m_hi, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi_lit", m_hi, 32'd1);
    // signed division, overflow case, divide by zero
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_lit", m_lo, 32'hFFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divov_lo_lit", m_lo, 32'h8000_0000);
    run_op(3'd3, 32'd5, 32'd0, 1'b0);
    chk("div0_hi_lit", m_hi, 32'd5);
    // refused requests while busy
    run_op(3'd3, 32'd100, 32'd7, 1'b1);
    chk("divu_hi_lit", m_hi, 32'd2);
    // back-to-back: DIVU accepted in the MULTU done cycle
    run_op(3'd1, 32'd3, 32'd4, 1'b0);
    run_op(3'd3, 32'd12, 32'd5, 1'b0);
    chk("b2b_lo_lit", m_lo, 32'd2);
    // reserved ops ignored
    run_op(3'd6, 32'h1111_1111, 32'd1, 1'b0);
    run_op(3'd7, 32'h2222_2222, 32'd1, 1'b0);
    run_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b0);
    run_op(3'd5, 32'hCAFE_0002, 32'd0, 1'b0);

    // reset mid-DIV aborts the operation
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs = 32'd1000; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_lo_keep", lo, 32'h0000_1234);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The module SHALL have parameter MULT_LAT, default 2, legal 1..4: rising edges from accept to HI/LO commit for MULT/MULTU.
REQ-002 The module SHALL have a single clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named as elsewhere in the codebase.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; sampled at clk rise.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 reserved.
REQ-007 rs  input  32  first operand (multiplicand/dividend/MTHI/MTLO source).
REQ-008 rt  input  32  second operand (multiplier/divisor).
REQ-009 busy  output  1  operation in flight; new requests refused.
REQ-010 done  output  1  one-cycle pulse on HI/LO commit of MULT/MULTU/DIV/DIVU.
REQ-011 hi  output  32  committed HI register.
REQ-012 lo  output  32  committed LO register.

Function
REQ-013 Accept SHALL occur at a rising edge where start=1, busy=0 and op<=5; op 6..7 SHALL be ignored with no state change.
REQ-014 start while busy=1 SHALL be ignored: no queueing, no operand capture, no HI/LO change.
REQ-015 rs/rt SHALL be captured at the accept edge (E0); later changes SHALL NOT affect the result.
REQ-016 FSM states SHALL be IDLE, MUL, DIV; IDLE->MUL on MULT/MULTU accept, IDLE->DIV on DIV/DIVU accept, MUL/DIV->IDLE on commit edge.
REQ-017 MTHI/MTLO SHALL write rs to hi/lo at E0, stay in IDLE, keep busy=0 and not pulse done.
REQ-018 MULT/MULTU SHALL commit at edge E0+MULT_LAT: hi=product[63:32], lo=product[31:0]; 64-bit product, signed for MULT, unsigned for MULTU.
REQ-019 DIV/DIVU SHALL commit at E0+33: E0 captures operand magnitudes, E1..E32 perform one restoring-division bit per edge, E33 applies signs and commits.
REQ-020 DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-021 Divisor zero (DIV or DIVU) SHALL commit lo=32'hFFFFFFFF and hi=rs unchanged, with the same 33-edge latency and no sign fix-up.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL commit lo=32'h80000000, hi=0.
REQ-023 busy SHALL be 1 from after E0 until the commit edge; in the cycle after commit, busy=0 and done=1 together.
REQ-024 A new accept SHALL be legal in the done cycle (back-to-back ops).
REQ-025 hi/lo SHALL hold their previous committed values throughout busy; no partial results SHALL be visible.
REQ-026 done SHALL be exactly one cycle wide per MULT/MULTU/DIV/DIVU; never for MTHI/MTLO or ignored requests.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear the iteration counter and datapath registers.
REQ-028 Reset asserted mid-operation SHALL abort it; after release, no done pulse and no commit from the aborted op SHALL occur.
REQ-029 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-030 MULT rs=32'hFFFFFFFF, rt=2 -> after MULT_LAT edges hi=32'hFFFFFFFF, lo=32'hFFFFFFFE; MULTU same operands -> hi=1, lo=32'hFFFFFFFE; one done each.
REQ-031 DIV rs=32'hFFFFFFF9 (-7), rt=2 -> busy 33 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-032 DIVU rs=5, rt=0 -> lo=32'hFFFFFFFF, hi=5 at E0+33.
REQ-033 DIVU 100/7 accepted; during busy issue start with op=MTHI rs=32'hDEAD and op=MULT -> both ignored; final hi=2, lo=14; single done.
REQ-034 Reset pulse at E0+10 of DIV -> busy=0, hi=lo=0 immediately; no done afterwards; MTLO rs=32'h1234 next edge -> lo=32'h1234.
REQ-035 Back-to-back: MULTU 3*4 followed by accept of DIVU 12/5 in the done cycle -> hi=0, lo=12, then hi=2, lo=2 after 33 more edges.
